gamedata_gen: RTL and testbench

GAMEDATA_GEN -- requirements
Module: gamedata_gen

---
 rtl/gamedata_pkg.sv | 24 ++
 rtl/gamedata_lfsr.sv | 23 ++
 rtl/gamedata_gen.sv | 137 +++++++++++++
 tb/tb_gamedata_gen.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/gamedata_pkg.sv
// Shared definitions for the stage-driven pattern generator: FSM states,
// default LFSR constants and small width/step helpers.
package gamedata_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GEN  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  localparam logic [7:0] DEFAULT_SEED = 8'hA5;
  localparam logic [7:0] DEFAULT_TAPS = 8'hB8;

  // Width of an index into n items, never below one bit.
  function automatic int id_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // One Galois step, evaluated at 16 bits; narrower LFSRs zero-extend in and truncate out.
  function automatic logic [15:0] lfsr_step(input logic [15:0] v, input logic [15:0] taps);
    return v[0] ? ((v >> 1) ^ taps) : (v >> 1);
  endfunction

endpackage

// File: rtl/gamedata_lfsr.sv
// Galois LFSR register: load has priority over step; the owner drives load during reset.
module gamedata_lfsr
  import gamedata_pkg::*;
#(
  parameter int                LFSR_W = 8,
  parameter logic [LFSR_W-1:0] TAPS   = LFSR_W'(DEFAULT_TAPS)
) (
  input  logic              clk,
  input  logic              load,
  input  logic [LFSR_W-1:0] load_val,
  input  logic              step,
  output logic [LFSR_W-1:0] q
);

  always_ff @(posedge clk) begin
    if (load) begin
      q <= load_val;
    end else if (step) begin
      q <= LFSR_W'(lfsr_step(16'(q), 16'(TAPS)));
    end
  end

endmodule

// File: rtl/gamedata_gen.sv
// Per-stage pattern generator: the highest newly requested stage reseeds the LFSR
// and fills min(stage+1, NUM_SYM) symbol slots, one per cycle, then holds them.
module gamedata_gen
  import gamedata_pkg::*;
#(
  parameter int                NUM_STAGES = 3,
  parameter int                NUM_SYM    = 3,
  parameter int                SYM_W      = 2,
  parameter int                LFSR_W     = 8,
  parameter logic [LFSR_W-1:0] TAPS       = LFSR_W'(DEFAULT_TAPS),
  parameter logic [LFSR_W-1:0] SEED       = LFSR_W'(DEFAULT_SEED),
  localparam int               ID_W       = id_width(NUM_STAGES)
) (
  input  logic                     clk,
  input  logic                     rstgame,
  input  logic [NUM_STAGES-1:0]    stage_req,
  output logic [NUM_SYM*SYM_W-1:0] data,
  output logic                     data_valid,
  output logic [ID_W-1:0]          stage_id,
  output logic                     busy
);

  localparam int CNT_W = id_width(NUM_SYM + 1);

  state_t            state_reg, state_next;
  logic [ID_W-1:0]   stage_id_reg, stage_id_next;
  logic              started_reg, started_next;
  logic [CNT_W-1:0]  sym_cnt_reg, sym_cnt_next;
  logic              data_valid_reg, data_valid_next;

  logic [ID_W-1:0]   target;
  logic              target_ok;
  logic [LFSR_W-1:0] seed_mix;
  int                active_slots;
  logic              last_slot;
  logic              clear_data, write_slot;
  logic              lfsr_load, lfsr_step_en;
  logic [LFSR_W-1:0] lfsr_load_val, lfsr_q;
  logic [SYM_W-1:0]  slot_new;

  gamedata_lfsr #(.LFSR_W(LFSR_W), .TAPS(TAPS)) u_lfsr (
    .clk      (clk),
    .load     (lfsr_load),
    .load_val (lfsr_load_val),
    .step     (lfsr_step_en),
    .q        (lfsr_q)
  );

  // Slot takes the value the LFSR is about to hold after this step.
  assign slot_new = SYM_W'(lfsr_step(16'(lfsr_q), 16'(TAPS)));

  always_comb begin
    target = '0;
    for (int k = 0; k < NUM_STAGES; k++) begin
      if (stage_req[k]) target = ID_W'(k);
    end
    target_ok = (|stage_req) && (!started_reg || (target > stage_id_reg));
    seed_mix  = SEED ^ LFSR_W'(target);
    if (seed_mix == '0) seed_mix = LFSR_W'(1);
    active_slots = (int'(stage_id_reg) + 1 < NUM_SYM) ? int'(stage_id_reg) + 1 : NUM_SYM;
    last_slot    = (int'(sym_cnt_reg) + 1 >= active_slots);
  end

  always_comb begin
    state_next      = state_reg;
    stage_id_next   = stage_id_reg;
    started_next    = started_reg;
    sym_cnt_next    = sym_cnt_reg;
    data_valid_next = data_valid_reg;
    clear_data      = 1'b0;
    write_slot      = 1'b0;
    lfsr_load       = 1'b0;
    lfsr_load_val   = seed_mix;
    lfsr_step_en    = 1'b0;
    case (state_reg)
      ST_IDLE, ST_HOLD: begin
        if (target_ok) begin
          state_next      = ST_GEN;
          stage_id_next   = target;
          started_next    = 1'b1;
          sym_cnt_next    = '0;
          data_valid_next = 1'b0;
          clear_data      = 1'b1;
          lfsr_load       = 1'b1;
        end
      end
      ST_GEN: begin
        lfsr_step_en = 1'b1;
        write_slot   = 1'b1;
        sym_cnt_next = sym_cnt_reg + CNT_W'(1);
        if (last_slot) begin
          state_next      = ST_HOLD;
          data_valid_next = 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
    // The LFSR has no reset of its own; reseed it with the base seed instead.
    if (rstgame) begin
      lfsr_load     = 1'b1;
      lfsr_load_val = SEED;
    end
  end

  always_ff @(posedge clk) begin
    if (rstgame) begin
      state_reg      <= ST_IDLE;
      stage_id_reg   <= '0;
      started_reg    <= 1'b0;
      sym_cnt_reg    <= '0;
      data_valid_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      stage_id_reg   <= stage_id_next;
      started_reg    <= started_next;
      sym_cnt_reg    <= sym_cnt_next;
      data_valid_reg <= data_valid_next;
    end
  end

  for (genvar gi = 0; gi < NUM_SYM; gi++) begin : g_slot
    logic [SYM_W-1:0] slot_reg;
    always_ff @(posedge clk) begin
      if (rstgame || clear_data) begin
        slot_reg <= '0;
      end else if (write_slot && (sym_cnt_reg == CNT_W'(gi))) begin
        slot_reg <= slot_new;
      end
    end
    assign data[gi*SYM_W +: SYM_W] = slot_reg;
  end

  assign data_valid = data_valid_reg;
  assign stage_id   = stage_id_reg;
  assign busy       = (state_reg == ST_GEN);

endmodule

// File: tb/tb_gamedata_gen.sv
// Bench for gamedata_gen: default instance plus a 5-stage/4-slot/3-bit instance,
// both compared every cycle against a transaction-level model.
module tb_gamedata_gen;

  logic        clk = 1'b0;
  logic        rstgame;
  logic [2:0]  req0;
  logic [4:0]  req1;
  logic [5:0]  data0;
  logic        valid0, busy0;
  logic [1:0]  id0;
  logic [11:0] data1;
  logic        valid1, busy1;
  logic [2:0]  id1;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  gamedata_gen dut0 (
    .clk(clk), .rstgame(rstgame), .stage_req(req0),
    .data(data0), .data_valid(valid0), .stage_id(id0), .busy(busy0)
  );

  gamedata_gen #(.NUM_STAGES(5), .NUM_SYM(4), .SYM_W(3)) dut1 (
    .clk(clk), .rstgame(rstgame), .stage_req(req1),
    .data(data1), .data_valid(valid1), .stage_id(id1), .busy(busy1)
  );

  // Model state per instance: current stage, whether a stage was played,
  // remaining generation cycles, valid flag and the finished pattern.
  int          m_stage[2];
  bit          m_started[2];
  int          m_left[2];
  bit          m_valid[2];
  logic [63:0] m_data[2];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int n_sym(input int k);
    return (k == 0) ? 3 : 4;
  endfunction

  function automatic int sym_w(input int k);
    return (k == 0) ? 2 : 3;
  endfunction

  function automatic int slots_for(input int k, input int t);
    return (t + 1 < n_sym(k)) ? t + 1 : n_sym(k);
  endfunction

  // Full pattern for stage t: seed = SEED^t (0 -> 1), step once per slot, keep low bits.
  function automatic logic [63:0] pattern(input int k, input int t);
    int l;
    logic [63:0] d;
    l = (8'hA5 ^ t) & 8'hFF;
    if (l == 0) l = 1;
    d = 0;
    for (int i = 0; i < slots_for(k, t); i++) begin
      l = ((l & 1) != 0) ? ((l >> 1) ^ 8'hB8) : (l >> 1);
      d = d | (64'(l & ((1 << sym_w(k)) - 1)) << (i * sym_w(k)));
    end
    return d;
  endfunction

  function automatic int hi_bit(input int r);
    int h;
    h = -1;
    for (int i = 0; i < 8; i++) if (((r >> i) & 1) != 0) h = i;
    return h;
  endfunction

  task automatic model_edge(input int k, input int r, input bit rst);
    int t;
    if (rst) begin
      m_stage[k] = 0; m_started[k] = 0; m_left[k] = 0; m_valid[k] = 0; m_data[k] = 0;
    end else if (m_left[k] > 0) begin
      m_left[k]--;
      if (m_left[k] == 0) m_valid[k] = 1;
    end else begin
      t = hi_bit(r);
      if (t >= 0 && (!m_started[k] || t > m_stage[k])) begin
        m_stage[k]   = t;
        m_started[k] = 1;
        m_left[k]    = slots_for(k, t);
        m_valid[k]   = 0;
        m_data[k]    = pattern(k, t);
      end
    end
  endtask

  function automatic logic [63:0] exp_data(input int k);
    return m_started[k] ? m_data[k] : 64'd0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    model_edge(0, int'(req0), rstgame);
    model_edge(1, int'(req1), rstgame);
    check("i0_busy",  64'(busy0),  64'(m_left[0] > 0));
    check("i0_valid", 64'(valid0), 64'(m_valid[0]));
    check("i0_id",    64'(id0),    64'(m_stage[0]));
    if (m_left[0] == 0) check("i0_data", 64'(data0), exp_data(0));
    check("i1_busy",  64'(busy1),  64'(m_left[1] > 0));
    check("i1_valid", 64'(valid1), 64'(m_valid[1]));
    check("i1_id",    64'(id1),    64'(m_stage[1]));
    if (m_left[1] == 0) check("i1_data", 64'(data1), exp_data(1));
  endtask

  initial begin
    rstgame = 1'b1; req0 = '0; req1 = '0;
    for (int k = 0; k < 2; k++) begin
      m_stage[k] = 0; m_started[k] = 0; m_left[k] = 0; m_valid[k] = 0; m_data[k] = 0;
    end
    tick();
    rstgame = 1'b0;
    repeat (10) tick();

    // Stage 0, then 1, then 2 on the default instance.
    req0 = 3'b001; repeat (4) tick();
    req0 = 3'b011; repeat (5) tick();
    req0 = 3'b111; repeat (6) tick();
    // Lower and dropped requests must not disturb the held stage.
    req0 = 3'b001; repeat (20) tick();
    req0 = 3'b000; repeat (20) tick();

    // Reset in the second generation cycle of stage 2, then replay stage 0.
    rstgame = 1'b1; tick();
    rstgame = 1'b0; req0 = 3'b111; tick(); tick();
    rstgame = 1'b1; tick();
    rstgame = 1'b0; req0 = 3'b000; tick();
    req0 = 3'b001; repeat (4) tick();

    // Wide instance jumps straight to its top stage.
    req1 = 5'b10000; repeat (8) tick();

    for (int i = 0; i < 400; i++) begin
      rstgame = ($urandom_range(0, 19) == 0);
      req0 = 3'($urandom);
      req1 = 5'($urandom);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
